// File: rtl/seg_scan_decoder.sv
// Receive-side seven-segment scan decoder: samples {dig_en, seg_in}, captures each stable digit once,
// maps it back to a hex nibble and publishes a full NUM_DIGITS word once per scan frame.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    value_valid,
  output logic [NUM_DIGITS-1:0]   seg_err_mask,
  output logic                    frame_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                  state;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic [CW-1:0]           cnt;
  logic                    captured;
  logic [NUM_DIGITS-1:0]   seen;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_err;

  logic                    same;
  logic                    cap_fire;
  logic                    multi_bits;
  logic                    cap_ok;
  logic                    multi_err;
  logic [IW-1:0]           idx;
  logic [4:0]              dec;
  logic [4*NUM_DIGITS-1:0] slot_val;
  logic [NUM_DIGITS-1:0]   slot_err;

  // Returns {undecodable, nibble}; undecodable patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h7E: return 5'h00;
      7'h30: return 5'h01;
      7'h6D: return 5'h02;
      7'h79: return 5'h03;
      7'h33: return 5'h04;
      7'h5B: return 5'h05;
      7'h5F: return 5'h06;
      7'h70: return 5'h07;
      7'h7F: return 5'h08;
      7'h7B: return 5'h09;
      7'h77: return 5'h0A;
      7'h1F: return 5'h0B;
      7'h4E: return 5'h0C;
      7'h3D: return 5'h0D;
      7'h4F: return 5'h0E;
      7'h47: return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  // The incoming sample is compared against the one already registered, so the
  // count reflects how many consecutive identical samples seg_q/dig_q now hold.
  assign same       = (seg_in == seg_q) && (dig_en == dig_q);
  assign cap_fire   = (cnt == CNT_MAX) && !captured;
  assign multi_bits = (dig_q & (dig_q - NUM_DIGITS'(1))) != '0;
  assign cap_ok     = cap_fire && (dig_q != '0) && !multi_bits;
  assign multi_err  = cap_fire && multi_bits;
  assign dec        = decode(seg_q);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q[i]) idx = IW'(i);
    end
    slot_val = '0;
    slot_val[4*idx +: 4] = dec[3:0];
    slot_err = dec[4] ? dig_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q    <= '0;
      dig_q    <= '0;
      cnt      <= '0;
      captured <= 1'b0;
    end else begin
      seg_q <= seg_in;
      dig_q <= dig_en;
      if (cap_fire) captured <= 1'b1;
      if (!same) begin
        cnt      <= CW'(1);
        captured <= 1'b0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      seen         <= '0;
      pend_val     <= '0;
      pend_err     <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      seg_err_mask <= '0;
      frame_err    <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      frame_err   <= multi_err;
      case (state)
        IDLE: begin
          if (cap_ok) begin
            pend_val[4*idx +: 4] <= dec[3:0];
            pend_err[idx]        <= dec[4];
            seen                 <= seen | dig_q;
            state                <= COLLECT;
          end
        end
        COLLECT: begin
          if (&seen) begin
            value        <= pend_val;
            seg_err_mask <= pend_err;
            value_valid  <= 1'b1;
            seen         <= '0;
            pend_err     <= '0;
            state        <= IDLE;
          end else if (cap_ok) begin
            if (seen[idx]) begin
              // Repeated slot: the scan lost sync, so restart the frame from this digit.
              frame_err <= 1'b1;
              seen      <= dig_q;
              pend_val  <= slot_val;
              pend_err  <= slot_err;
            end else begin
              pend_val[4*idx +: 4] <= dec[3:0];
              pend_err[idx]        <= dec[4];
              seen                 <= seen | dig_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
